// File: rtl/alu_control_unit.sv
// Multi-cycle decoder/sequencer driving the 8-bit ALU and register file.
// Optional feature: define ALU_CTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes.
module alu_control_unit #(
    parameter int unsigned ADD_CYCLES   = 2,
    parameter int unsigned LOGIC_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic [2:0]  ALUOP,
    output logic        IMM_SEL,
    output logic        NEG_SEL,
    output logic [7:0]  IMMEDIATE,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    output logic [2:0]  WRITEREG,
    output logic        WRITE_EN,
    output logic        BUSY,
    output logic        ILLEGAL
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned OP_W  = 8;

    localparam logic [OP_W-1:0] OP_LOADI = 8'h00;
    localparam logic [OP_W-1:0] OP_MOV   = 8'h01;
    localparam logic [OP_W-1:0] OP_ADD   = 8'h02;
    localparam logic [OP_W-1:0] OP_SUB   = 8'h03;
    localparam logic [OP_W-1:0] OP_AND   = 8'h04;
    localparam logic [OP_W-1:0] OP_OR    = 8'h05;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
`endif

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [OP_W-1:0]  opcode_q;
    logic             accept;
    logic             op_illegal_q;
    logic             op_arith_q;
    logic             new_illegal;

    // Address fields only use their low 3 bits; the rest is deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op > OP_OR;
    endfunction

    function automatic logic [2:0] aluop_of(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB: aluop_of = 3'b001;
            OP_AND:         aluop_of = 3'b010;
            OP_OR:          aluop_of = 3'b011;
            default:        aluop_of = 3'b000;
        endcase
    endfunction

    assign op_illegal_q = is_illegal(opcode_q);
    assign op_arith_q   = (opcode_q == OP_ADD) || (opcode_q == OP_SUB);
    assign new_illegal  = accept && is_illegal(INSTRUCTION[31:24]);

    // State and execute counter register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (INSTR_VALID && INSTR_READY) begin
                    accept     = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (op_illegal_q) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                    next_state = HALT;
`else
                    next_state = IDLE;
`endif
                end else begin
                    next_state = EXEC;
                    cnt_next   = op_arith_q ? CNT_W'(ADD_CYCLES - 1) : CNT_W'(LOGIC_CYCLES - 1);
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    next_state = WB;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            WB:      next_state = IDLE;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            HALT:    next_state = HALT;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs; decoded fields load only on the edge that enters DECODE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            INSTR_READY <= 1'b0;
            BUSY        <= 1'b0;
            WRITE_EN    <= 1'b0;
            ILLEGAL     <= 1'b0;
            opcode_q    <= '0;
            ALUOP       <= 3'b000;
            IMM_SEL     <= 1'b0;
            NEG_SEL     <= 1'b0;
            IMMEDIATE   <= '0;
            READREG1    <= '0;
            READREG2    <= '0;
            WRITEREG    <= '0;
        end else begin
            INSTR_READY <= (next_state == IDLE);
            BUSY        <= (next_state != IDLE);
            WRITE_EN    <= (next_state == WB);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            ILLEGAL     <= ILLEGAL | new_illegal;
`else
            ILLEGAL     <= new_illegal;
`endif
            if (accept) begin
                opcode_q  <= INSTRUCTION[31:24];
                ALUOP     <= aluop_of(INSTRUCTION[31:24]);
                IMM_SEL   <= (INSTRUCTION[31:24] == OP_LOADI);
                NEG_SEL   <= (INSTRUCTION[31:24] == OP_SUB);
                IMMEDIATE <= INSTRUCTION[7:0];
                READREG1  <= INSTRUCTION[10:8];
                READREG2  <= INSTRUCTION[2:0];
                WRITEREG  <= INSTRUCTION[18:16];
            end
        end
    end

endmodule
